// File: rtl/mavg_pkg.sv
// Shared constants and elaboration-time helpers for the moving-average filter.
package mavg_pkg;

  localparam int MIN_WIN_LEN = 2;
  localparam int MAX_WIN_LEN = 1024;

  // Saturation outcome of the final shift stage.
  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sum_w(input int data_w, input int win_len);
    return data_w + clog2(win_len);
  endfunction

  function automatic int prod_w(input int data_w, input int win_len, input int shift);
    return sum_w(data_w, win_len) + shift + 1;
  endfunction

  // round(2^shift / win_len)
  function automatic longint recip(input int win_len, input int shift);
    return ((longint'(1) << shift) + longint'(win_len / 2)) / longint'(win_len);
  endfunction

  // Signed limits of a data_w-bit word (data_w <= 64).
  function automatic longint sat_hi(input int data_w);
    return (longint'(1) << (data_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int data_w);
    return -(longint'(1) << (data_w - 1));
  endfunction

endpackage

// File: rtl/mavg_delay_line.sv
// WIN_LEN x DATA_W circular sample buffer: read-old / write-new at the same slot.
module mavg_delay_line
  import mavg_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int WIN_LEN = 74
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int PTR_W = clog2(WIN_LEN);

  // No reset on the array so it maps onto distributed RAM.
  logic [DATA_W-1:0] r_mem [WIN_LEN];
  logic [PTR_W-1:0]  r_wr_ptr;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (i_we) begin
      if (r_wr_ptr == PTR_W'(WIN_LEN - 1)) r_wr_ptr <= '0;
      else                                 r_wr_ptr <= r_wr_ptr + PTR_W'(1);
    end
  end

  assign o_rdata = r_mem[r_wr_ptr];

endmodule

// File: rtl/axis_mavg_param.sv
// N-point moving average, AXI-Stream in/out, 3-stage pipeline with full backpressure.
// Define MAVG_ROUND_EN for round-half-up scaling instead of flooring.
module axis_mavg_param
  import mavg_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int WIN_LEN = 74,
  parameter int SHIFT   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tuser
);

  localparam int SUM_W  = sum_w(DATA_W, WIN_LEN);
  localparam int PROD_W = prod_w(DATA_W, WIN_LEN, SHIFT);
  localparam int CNT_W  = clog2(WIN_LEN + 1);
  localparam int HI_W   = PROD_W - DATA_W + 1;
  localparam logic [SHIFT:0]        RECIP   = (SHIFT + 1)'(recip(WIN_LEN, SHIFT));
  localparam logic [DATA_W-1:0]     SAT_MAX = DATA_W'(sat_hi(DATA_W));
  localparam logic [DATA_W-1:0]     SAT_MIN = DATA_W'(sat_lo(DATA_W));

  // Handshake: a beat moves on either port when its valid and ready are both
  // high at the clock edge. The whole pipeline advances only when the output
  // register is empty or being drained, so s_axis_tready is combinational on
  // m_axis_tready; s_axis_tvalid never reaches m_axis_* combinationally.
  logic w_en;
  logic w_accept;
  assign w_en          = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = w_en;
  assign w_accept      = s_axis_tvalid & w_en;

  logic [DATA_W-1:0] w_old;

  mavg_delay_line #(
    .DATA_W  (DATA_W),
    .WIN_LEN (WIN_LEN)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_accept),
    .i_wdata (s_axis_tdata),
    .o_rdata (w_old)
  );

  logic signed [SUM_W-1:0]  r_sum;
  logic [CNT_W-1:0]         r_fill;
  logic                     r_s1_valid, r_s1_user;
  logic                     r_s2_valid, r_s2_user;
  logic signed [PROD_W-1:0] r_s2_prod;
  logic                     w_full;
  logic signed [SUM_W-1:0]  w_x, w_y;

  // Until the window has filled, the slot being overwritten holds stale data.
  assign w_full = (r_fill == CNT_W'(WIN_LEN));
  assign w_x    = $signed({{(SUM_W - DATA_W){s_axis_tdata[DATA_W-1]}}, s_axis_tdata});
  assign w_y    = w_full ? $signed({{(SUM_W - DATA_W){w_old[DATA_W-1]}}, w_old}) : '0;

  logic signed [PROD_W-1:0] w_sum_ext, w_recip_ext, w_prod_adj, w_shifted;
  logic [HI_W-1:0]          w_hi;
  sat_e                     w_sat;

  assign w_sum_ext   = $signed({{(PROD_W - SUM_W){r_sum[SUM_W-1]}}, r_sum});
  assign w_recip_ext = $signed({{(PROD_W - SHIFT - 1){1'b0}}, RECIP});

`ifdef MAVG_ROUND_EN
  localparam logic [PROD_W-1:0] ROUND_K = {{(PROD_W - 1){1'b0}}, 1'b1} << (SHIFT - 1);
  assign w_prod_adj = r_s2_prod + $signed(ROUND_K);
`else
  assign w_prod_adj = r_s2_prod;
`endif

  assign w_shifted = w_prod_adj >>> SHIFT;
  assign w_hi      = w_shifted[PROD_W-1:DATA_W-1];

  always_comb begin
    w_sat = SAT_NONE;
    if (!((&w_hi) || (~|w_hi))) w_sat = w_shifted[PROD_W-1] ? SAT_LO : SAT_HI;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum         <= '0;
      r_fill        <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_user     <= 1'b0;
      r_s2_valid    <= 1'b0;
      r_s2_user     <= 1'b0;
      r_s2_prod     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
    end else if (w_en) begin
      // S1: window update
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_sum     <= r_sum + w_x - w_y;
        r_s1_user <= w_full | (r_fill == CNT_W'(WIN_LEN - 1));
        if (!w_full) r_fill <= r_fill + CNT_W'(1);
      end
      // S2: scale by the reciprocal
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_prod <= w_sum_ext * w_recip_ext;
        r_s2_user <= r_s1_user;
      end
      // S3: shift, saturate, register output
      m_axis_tvalid <= r_s2_valid;
      if (r_s2_valid) begin
        m_axis_tuser <= r_s2_user;
        case (w_sat)
          SAT_HI:  m_axis_tdata <= SAT_MAX;
          SAT_LO:  m_axis_tdata <= SAT_MIN;
          default: m_axis_tdata <= w_shifted[DATA_W-1:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_mavg_param.sv
// Scoreboard bench: a small-window instance for ramps/backpressure/reset and a
// default-parameter instance for saturation, both against a sliding-window model.
`timescale 1ns/1ps
module tb_axis_mavg_param;

  localparam int DW   = 32;
  localparam int A_N  = 4;
  localparam int A_SH = 8;
  localparam int B_N  = 74;
  localparam int B_SH = 20;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_m_user;
  logic [DW-1:0] a_s_data, a_m_data;
  logic          b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_user;
  logic [DW-1:0] b_s_data, b_m_data;

  axis_mavg_param #(.DATA_W(DW), .WIN_LEN(A_N), .SHIFT(A_SH)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(a_s_valid), .s_axis_tready(a_s_ready), .s_axis_tdata(a_s_data),
    .m_axis_tvalid(a_m_valid), .m_axis_tready(a_m_ready), .m_axis_tdata(a_m_data),
    .m_axis_tuser(a_m_user)
  );

  axis_mavg_param dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(b_s_valid), .s_axis_tready(b_s_ready), .s_axis_tdata(b_s_data),
    .m_axis_tvalid(b_m_valid), .m_axis_tready(b_m_ready), .m_axis_tdata(b_m_data),
    .m_axis_tuser(b_m_user)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] a_exp_q[$], b_exp_q[$];
  logic          a_usr_q[$], b_usr_q[$];
  longint        a_hist[$], b_hist[$];
  int            a_seen, b_seen;
  logic [DW-1:0] b_last;

  function automatic logic [DW-1:0] model_out(input longint sum, input int n, input int sh);
    longint rc, p, q;
    rc = ((longint'(1) << sh) + longint'(n / 2)) / longint'(n);
    p  = sum * rc;
`ifdef MAVG_ROUND_EN
    p  = p + (longint'(1) << (sh - 1));
`endif
    q  = p >>> sh;
    if (q > SMAX) q = SMAX;
    if (q < SMIN) q = SMIN;
    return q[DW-1:0];
  endfunction

  task automatic a_push(input logic [DW-1:0] d);
    longint s;
    a_hist.push_back(longint'($signed(d)));
    if (a_hist.size() > A_N) void'(a_hist.pop_front());
    s = 0;
    foreach (a_hist[i]) s += a_hist[i];
    a_seen++;
    a_exp_q.push_back(model_out(s, A_N, A_SH));
    a_usr_q.push_back(a_seen >= A_N);
  endtask

  task automatic b_push(input logic [DW-1:0] d);
    longint s;
    b_hist.push_back(longint'($signed(d)));
    if (b_hist.size() > B_N) void'(b_hist.pop_front());
    s = 0;
    foreach (b_hist[i]) s += b_hist[i];
    b_seen++;
    b_exp_q.push_back(model_out(s, B_N, B_SH));
    b_usr_q.push_back(b_seen >= B_N);
  endtask

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic a_cycle(input logic v, input logic [DW-1:0] d, input logic rdy, output logic acc);
    @(negedge clk);
    a_s_valid = v;
    a_s_data  = d;
    a_m_ready = rdy;
    #1;
    acc = v && a_s_ready;
    if (acc) a_push(d);
  endtask

  task automatic b_cycle(input logic v, input logic [DW-1:0] d, input logic rdy, output logic acc);
    @(negedge clk);
    b_s_valid = v;
    b_s_data  = d;
    b_m_ready = rdy;
    #1;
    acc = v && b_s_ready;
    if (acc) b_push(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    a_s_valid = 1'b0;
    b_s_valid = 1'b0;
    #1;
    check("a_rst_m_valid", 64'(a_m_valid), 64'd0);
    check("a_rst_m_data",  64'(a_m_data),  64'd0);
    check("a_rst_m_user",  64'(a_m_user),  64'd0);
    check("a_rst_s_ready", 64'(a_s_ready), 64'd1);
    check("b_rst_m_valid", 64'(b_m_valid), 64'd0);
    a_exp_q.delete(); a_usr_q.delete(); a_hist.delete(); a_seen = 0;
    b_exp_q.delete(); b_usr_q.delete(); b_hist.delete(); b_seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic a_drain();
    logic acc;
    for (int i = 0; i < 60 && a_exp_q.size() != 0; i++) a_cycle(1'b0, '0, 1'b1, acc);
    a_cycle(1'b0, '0, 1'b1, acc);
    check("a_drain_empty", 64'(a_exp_q.size()), 64'd0);
  endtask

  task automatic b_drain();
    logic acc;
    for (int i = 0; i < 60 && b_exp_q.size() != 0; i++) b_cycle(1'b0, '0, 1'b1, acc);
    b_cycle(1'b0, '0, 1'b1, acc);
    check("b_drain_empty", 64'(b_exp_q.size()), 64'd0);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin : mon_a
    logic [DW-1:0] e;
    logic          u;
    #2;
    if (rst_n && a_m_valid && a_m_ready) begin
      checks++;
      if (a_exp_q.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected: got %0d, expected no output", $signed(a_m_data));
      end else begin
        e = a_exp_q.pop_front();
        u = a_usr_q.pop_front();
        if (a_m_data !== e || a_m_user !== u) begin
          errors++;
          $display("FAIL a_out: got data %0d user %0b, expected data %0d user %0b",
                   $signed(a_m_data), a_m_user, $signed(e), u);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [DW-1:0] e;
    logic          u;
    #2;
    if (rst_n && b_m_valid && b_m_ready) begin
      checks++;
      b_last = b_m_data;
      if (b_exp_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got %0h, expected no output", b_m_data);
      end else begin
        e = b_exp_q.pop_front();
        u = b_usr_q.pop_front();
        if (b_m_data !== e || b_m_user !== u) begin
          errors++;
          $display("FAIL b_out: got data %0h user %0b, expected data %0h user %0b",
                   b_m_data, b_m_user, e, u);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic          acc, pend, rdy;
    logic [DW-1:0] d, frozen;
    int            cnt, nd;
    a_s_valid = 1'b0; a_s_data = '0; a_m_ready = 1'b1;
    b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b1;
    b_last = '0;
    repeat (3) @(negedge clk);
    do_reset();

    // constant 1000: ramp and 3-cycle latency
    for (int k = 0; k < 12; k++) begin
      a_cycle(1'b1, 32'd1000, 1'b1, acc);
      if (k >= 1 && k <= 3) check("a_latency", 64'(a_m_valid), 64'(k == 3));
    end
    a_drain();

    // constant -8
    do_reset();
    for (int k = 0; k < 10; k++) a_cycle(1'b1, 32'hFFFF_FFF8, 1'b1, acc);
    a_drain();

    // single 2 then zeros
    do_reset();
    a_cycle(1'b1, 32'd2, 1'b1, acc);
    for (int k = 0; k < 7; k++) a_cycle(1'b1, 32'd0, 1'b1, acc);
    a_drain();

    // output stall with continuous input
    do_reset();
    cnt = 0; nd = 1; frozen = '0;
    for (int k = 0; k < 10; k++) begin
      a_cycle(1'b1, DW'(nd * 100), 1'b0, acc);
      if (acc) begin cnt++; nd++; end
      if (k == 4) frozen = a_m_data;
    end
    check("a_stall_accepts", 64'(cnt), 64'd3);
    check("a_stall_s_ready", 64'(a_s_ready), 64'd0);
    check("a_stall_m_valid", 64'(a_m_valid), 64'd1);
    check("a_stall_frozen",  64'(a_m_data), 64'(frozen));
    for (int k = 0; k < 10; k++) begin
      a_cycle(1'b1, DW'(nd * 100), 1'b1, acc);
      if (acc) nd++;
    end
    a_drain();

    // reset mid-stream then fresh ramp
    do_reset();
    for (int k = 0; k < 5; k++) a_cycle(1'b1, 32'd500, 1'b1, acc);
    do_reset();
    for (int k = 0; k < 8; k++) a_cycle(1'b1, 32'd1000, 1'b1, acc);
    a_drain();

    // randomized traffic with random backpressure
    do_reset();
    pend = 1'b0; d = '0;
    for (int k = 0; k < 400; k++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) d = DW'($urandom());
        else                           d = DW'(int'($urandom_range(0, 2000)) - 1000);
      end
      rdy = ($urandom_range(0, 3) != 0);
      a_cycle(pend, d, rdy, acc);
      if (acc) pend = 1'b0;
    end
    a_drain();

    // default parameters: full-scale saturation
    do_reset();
    for (int k = 0; k < 80; k++) b_cycle(1'b1, 32'h7FFF_FFFF, 1'b1, acc);
    b_drain();
    check("b_sat_hi", 64'(b_last), 64'h7FFF_FFFF);
    for (int k = 0; k < 80; k++) b_cycle(1'b1, 32'h8000_0000, 1'b1, acc);
    b_drain();
    check("b_sat_lo", 64'(b_last), 64'h8000_0000);
    pend = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 2) != 0);
        d    = DW'($urandom());
      end
      rdy = ($urandom_range(0, 2) != 0);
      b_cycle(pend, d, rdy, acc);
      if (acc) pend = 1'b0;
    end
    b_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
